// File: rtl/phase_sequencer_if.sv
// Control and status bundle for the N-phase sequencer.
// The master side (controller) sets mode, direction, rate and step requests.
// The slave side (sequencer) returns the phase drive and step/wrap status.
interface phase_sequencer_if #(
  parameter int N_PHASE = 4,
  parameter int DIV_W   = 8,
  parameter int IDX_W   = $clog2(2 * N_PHASE)
);
  logic               EN;
  logic               DIR;
  logic [1:0]         MODE;
  logic [DIV_W-1:0]   DIV;
  logic               STEP_ONCE;
  logic [N_PHASE-1:0] PHASE;
  logic [IDX_W-1:0]   STEP_IDX;
  logic               STEP_TICK;
  logic               WRAP;

  modport master (
    output EN, DIR, MODE, DIV, STEP_ONCE,
    input  PHASE, STEP_IDX, STEP_TICK, WRAP
  );

  modport slave (
    input  EN, DIR, MODE, DIV, STEP_ONCE,
    output PHASE, STEP_IDX, STEP_TICK, WRAP
  );
endinterface

// File: rtl/phase_sequencer.sv
// N-phase output sequencer for LED chasers and unipolar stepper drivers.
// Position is kept in half-step units (0..2N-1). Wave and full-step modes
// move two units per step, half-step mode moves one. A prescaler spaces
// free-running steps DIV+1 enabled cycles apart; STEP_ONCE steps manually
// while the prescaler is disabled. All outputs come straight from flops.
module phase_sequencer #(
  parameter int N_PHASE = 4,
  parameter int DIV_W   = 8
) (
  input logic               C_IN,
  input logic               RST,
  phase_sequencer_if.slave  bus
);
  localparam int IDX_W = $clog2(2 * N_PHASE);
  localparam logic [IDX_W:0]     POS_N   = (IDX_W + 1)'(2 * N_PHASE);
  localparam logic [IDX_W-1:0]   K_LAST  = IDX_W'(N_PHASE - 1);
  localparam logic [N_PHASE-1:0] ONE_HOT = N_PHASE'(1);
  localparam logic [1:0]         MODE_WAVE = 2'b00;
  localparam logic [1:0]         MODE_FULL = 2'b01;
  localparam logic [1:0]         MODE_HALF = 2'b10;
  localparam logic [1:0]         MODE_OFF  = 2'b11;

  logic [IDX_W-1:0]   pos_q, pos_d, pos_step;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [N_PHASE-1:0] phase_q, phase_d;
  logic               tick_q, tick_d;
  logic               wrap_q, wrap_d;
  logic               step;
  logic               mode_off;

  // Next position one step away, modulo 2N. Whole steps first drop to the
  // even position below so a mode switch skips at most one half-step.
  function automatic logic [IDX_W-1:0] next_pos(
    input logic [IDX_W-1:0] p,
    input logic             half,
    input logic             rev
  );
    logic [IDX_W:0] base;
    logic [IDX_W:0] inc;
    logic [IDX_W:0] t;
    base = half ? {1'b0, p} : {1'b0, p[IDX_W-1:1], 1'b0};
    inc  = half ? (IDX_W + 1)'(1) : (IDX_W + 1)'(2);
    if (!rev) begin
      t = base + inc;
      if (t >= POS_N) t = t - POS_N;
    end else begin
      if (base < inc) t = base + POS_N - inc;
      else            t = base - inc;
    end
    return t[IDX_W-1:0];
  endfunction

  // Phase pattern for a position: coil k alone, or coils k and k+1 (wrapping).
  function automatic logic [N_PHASE-1:0] decode(
    input logic [IDX_W-1:0] p,
    input logic [1:0]       m
  );
    logic [IDX_W-1:0]   k;
    logic [IDX_W-1:0]   k_nxt;
    logic [N_PHASE-1:0] lo;
    logic [N_PHASE-1:0] hi;
    logic [N_PHASE-1:0] d;
    k     = p >> 1;
    k_nxt = (k == K_LAST) ? '0 : k + IDX_W'(1);
    lo    = ONE_HOT << k;
    hi    = ONE_HOT << k_nxt;
    case (m)
      MODE_WAVE: d = lo;
      MODE_FULL: d = lo | hi;
      MODE_HALF: d = p[0] ? (lo | hi) : lo;
      default:   d = '0;
    endcase
    return d;
  endfunction

  // Step decision, prescaler, position update and output decode.
  always_comb begin
    mode_off = (bus.MODE == MODE_OFF);
    step     = !mode_off &&
               ((bus.EN && (cnt_q >= bus.DIV)) || (!bus.EN && bus.STEP_ONCE));

    cnt_d = cnt_q;
    if (mode_off)                        cnt_d = '0;
    else if (bus.EN && (cnt_q >= bus.DIV)) cnt_d = '0;
    else if (bus.EN)                     cnt_d = cnt_q + DIV_W'(1);

    pos_step = next_pos(pos_q, bus.MODE == MODE_HALF, bus.DIR);
    pos_d    = step ? pos_step : pos_q;
    wrap_d   = step && (bus.DIR ? (pos_step > pos_q) : (pos_step < pos_q));
    tick_d   = step;
    phase_d  = decode(pos_d, bus.MODE);
  end

  // State and output registers; reset overrides every input.
  always_ff @(posedge C_IN) begin
    if (RST) begin
      pos_q   <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.PHASE     = phase_q;
  assign bus.STEP_IDX  = pos_q;
  assign bus.STEP_TICK = tick_q;
  assign bus.WRAP      = wrap_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer with N_PHASE=4: a vector table for
// per-cycle behaviour plus hand-written multi-cycle sequences.
module tb_phase_sequencer;
  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;

  phase_sequencer_if #(.N_PHASE(N), .DIV_W(DW)) bus ();

  phase_sequencer #(.N_PHASE(N), .DIV_W(DW)) dut (
    .C_IN (clk),
    .RST  (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic       dir;
    logic [1:0] mode;
    logic [7:0] div;
    logic       so;
    logic [3:0] ph;
    logic [2:0] idx;
    logic       tick;
    logic       wrap;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mkv(input logic r, input logic en, input logic dir,
                               input logic [1:0] mode, input logic [7:0] div,
                               input logic so, input logic [3:0] ph,
                               input logic [2:0] idx, input logic tick,
                               input logic wrap);
    vec_t v;
    v.rst = r; v.en = en; v.dir = dir; v.mode = mode; v.div = div; v.so = so;
    v.ph = ph; v.idx = idx; v.tick = tick; v.wrap = wrap;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ph,
                         input logic [2:0] idx, input logic tick,
                         input logic wrap);
    checks++;
    if (bus.PHASE !== ph) begin
      errors++;
      $display("FAIL %s PHASE actual=%b required=%b", tag, bus.PHASE, ph);
    end
    checks++;
    if (bus.STEP_IDX !== idx) begin
      errors++;
      $display("FAIL %s STEP_IDX actual=%0d required=%0d", tag, bus.STEP_IDX, idx);
    end
    checks++;
    if (bus.STEP_TICK !== tick) begin
      errors++;
      $display("FAIL %s STEP_TICK actual=%b required=%b", tag, bus.STEP_TICK, tick);
    end
    checks++;
    if (bus.WRAP !== wrap) begin
      errors++;
      $display("FAIL %s WRAP actual=%b required=%b", tag, bus.WRAP, wrap);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] hp[8];
    hp[0] = 4'b0011; hp[1] = 4'b0010; hp[2] = 4'b0110; hp[3] = 4'b0100;
    hp[4] = 4'b1100; hp[5] = 4'b1000; hp[6] = 4'b1001; hp[7] = 4'b0001;

    //                rst   en    dir   mode   div   so    ph       idx   tick  wrap
    // wave forward, DIV=0
    vecs[0]  = mkv(1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0);
    vecs[1]  = mkv(1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 1'b0, 4'b0001, 3'd0, 1'b0, 1'b0);
    vecs[2]  = mkv(1'b0, 1'b1, 1'b0, 2'b00, 8'd0, 1'b0, 4'b0010, 3'd2, 1'b1, 1'b0);
    vecs[3]  = mkv(1'b0, 1'b1, 1'b0, 2'b00, 8'd0, 1'b0, 4'b0100, 3'd4, 1'b1, 1'b0);
    vecs[4]  = mkv(1'b0, 1'b1, 1'b0, 2'b00, 8'd0, 1'b0, 4'b1000, 3'd6, 1'b1, 1'b0);
    vecs[5]  = mkv(1'b0, 1'b1, 1'b0, 2'b00, 8'd0, 1'b0, 4'b0001, 3'd0, 1'b1, 1'b1);
    // full-step reverse from reset
    vecs[6]  = mkv(1'b1, 1'b0, 1'b1, 2'b01, 8'd0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0);
    vecs[7]  = mkv(1'b0, 1'b0, 1'b1, 2'b01, 8'd0, 1'b0, 4'b0011, 3'd0, 1'b0, 1'b0);
    vecs[8]  = mkv(1'b0, 1'b1, 1'b1, 2'b01, 8'd0, 1'b0, 4'b1001, 3'd6, 1'b1, 1'b1);
    vecs[9]  = mkv(1'b0, 1'b1, 1'b1, 2'b01, 8'd0, 1'b0, 4'b1100, 3'd4, 1'b1, 1'b0);
    vecs[10] = mkv(1'b0, 1'b1, 1'b1, 2'b01, 8'd0, 1'b0, 4'b0110, 3'd2, 1'b1, 1'b0);
    vecs[11] = mkv(1'b0, 1'b1, 1'b1, 2'b01, 8'd0, 1'b0, 4'b0011, 3'd0, 1'b1, 1'b0);
    // half-step reverse wrap, then wave forward from an odd position snaps
    vecs[12] = mkv(1'b1, 1'b0, 1'b1, 2'b10, 8'd0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0);
    vecs[13] = mkv(1'b0, 1'b1, 1'b1, 2'b10, 8'd0, 1'b0, 4'b1001, 3'd7, 1'b1, 1'b1);
    vecs[14] = mkv(1'b0, 1'b1, 1'b1, 2'b10, 8'd0, 1'b0, 4'b1000, 3'd6, 1'b1, 1'b0);
    vecs[15] = mkv(1'b0, 1'b1, 1'b1, 2'b10, 8'd0, 1'b0, 4'b1100, 3'd5, 1'b1, 1'b0);
    vecs[16] = mkv(1'b0, 1'b1, 1'b0, 2'b00, 8'd0, 1'b0, 4'b1000, 3'd6, 1'b1, 1'b0);

    rst = 1'b1;
    bus.EN = 1'b0; bus.DIR = 1'b0; bus.MODE = 2'b00; bus.DIV = '0; bus.STEP_ONCE = 1'b0;

    for (int i = 0; i < 17; i++) begin
      rst           = vecs[i].rst;
      bus.EN        = vecs[i].en;
      bus.DIR       = vecs[i].dir;
      bus.MODE      = vecs[i].mode;
      bus.DIV       = vecs[i].div;
      bus.STEP_ONCE = vecs[i].so;
      cyc();
      chk_out($sformatf("vec%0d", i), vecs[i].ph, vecs[i].idx, vecs[i].tick, vecs[i].wrap);
    end

    // half-step at DIV=2: each pattern held three cycles
    rst = 1'b1; bus.EN = 1'b1; bus.DIR = 1'b0; bus.MODE = 2'b10; bus.DIV = 8'd2;
    bus.STEP_ONCE = 1'b0;
    cyc();
    chk_out("hs_reset", 4'b0000, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int h = 0; h < 2; h++) begin
      cyc();
      chk_out($sformatf("hs_pre%0d", h), 4'b0001, 3'd0, 1'b0, 1'b0);
    end
    for (int s = 0; s < 8; s++) begin
      cyc();
      chk_out($sformatf("hs_step%0d", s), hp[s], 3'((s + 1) % 8), 1'b1, s == 7);
      for (int h = 0; h < 2; h++) begin
        cyc();
        chk_out($sformatf("hs_hold%0d_%0d", s, h), hp[s], 3'((s + 1) % 8), 1'b0, 1'b0);
      end
    end

    // single-step pulses with EN=0, then off and back on
    rst = 1'b1; bus.EN = 1'b0; bus.DIR = 1'b0; bus.MODE = 2'b00; bus.DIV = 8'd0;
    bus.STEP_ONCE = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    chk_out("ss_idle", 4'b0001, 3'd0, 1'b0, 1'b0);
    for (int p = 0; p < 3; p++) begin
      bus.STEP_ONCE = 1'b1;
      cyc();
      chk_out($sformatf("ss_pulse%0d", p), 4'(4'b0001 << (p + 1)), 3'(2 * (p + 1)), 1'b1, 1'b0);
      bus.STEP_ONCE = 1'b0;
      for (int h = 0; h < 3; h++) begin
        cyc();
        chk_out($sformatf("ss_gap%0d_%0d", p, h), 4'(4'b0001 << (p + 1)), 3'(2 * (p + 1)), 1'b0, 1'b0);
      end
    end
    bus.MODE = 2'b11;
    cyc();
    chk_out("off_enter", 4'b0000, 3'd6, 1'b0, 1'b0);
    bus.STEP_ONCE = 1'b1;
    cyc();
    chk_out("off_stepreq", 4'b0000, 3'd6, 1'b0, 1'b0);
    bus.STEP_ONCE = 1'b0;
    bus.MODE = 2'b00;
    cyc();
    chk_out("off_leave", 4'b1000, 3'd6, 1'b0, 1'b0);

    // DIV shrink below the running count
    rst = 1'b1; bus.EN = 1'b1; bus.DIR = 1'b0; bus.MODE = 2'b00; bus.DIV = 8'd7;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_out($sformatf("dv_count%0d", i), 4'b0001, 3'd0, 1'b0, 1'b0);
    end
    bus.DIV = 8'd1;
    cyc(); chk_out("dv_step0", 4'b0010, 3'd2, 1'b1, 1'b0);
    cyc(); chk_out("dv_gap0",  4'b0010, 3'd2, 1'b0, 1'b0);
    cyc(); chk_out("dv_step1", 4'b0100, 3'd4, 1'b1, 1'b0);
    cyc(); chk_out("dv_gap1",  4'b0100, 3'd4, 1'b0, 1'b0);
    cyc(); chk_out("dv_step2", 4'b1000, 3'd6, 1'b1, 1'b0);

    // reset pulse on a cycle that would otherwise step
    rst = 1'b1; bus.EN = 1'b1; bus.DIR = 1'b0; bus.MODE = 2'b10; bus.DIV = 8'd3;
    cyc();
    rst = 1'b0;
    cyc(); cyc(); cyc();
    chk_out("rm_run", 4'b0001, 3'd0, 1'b0, 1'b0);
    rst = 1'b1; bus.STEP_ONCE = 1'b1;
    cyc();
    chk_out("rm_reset", 4'b0000, 3'd0, 1'b0, 1'b0);
    rst = 1'b0; bus.STEP_ONCE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_out($sformatf("rm_wait%0d", i), 4'b0001, 3'd0, 1'b0, 1'b0);
    end
    cyc();
    chk_out("rm_first", 4'b0011, 3'd1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
